// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the run-time configurable serial pattern detector.
// Holds the control-state encoding, counter saturation constant and length clamp.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        HIT
    } state_t;

    // Widest supported match counter; narrower counters take the low bits.
    localparam int unsigned CNT_W_MAX = 16;
    localparam logic [CNT_W_MAX-1:0] CNT_ALL_ONES = '1;

    function automatic int unsigned clamp_len(input int unsigned l, input int unsigned max_len);
        return (l > max_len) ? max_len : l;
    endfunction

endpackage

// File: rtl/seq_det_n_sat_counter.sv
// Saturating up-counter with registered saturation flag; 1-cycle update latency.
// No backpressure: inc is counted on every edge until all-ones, then ignored.
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         ck,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         sat
);

    localparam logic [W-1:0] MAX_Q = CNT_ALL_ONES[W-1:0];

    logic [W-1:0] r_q;
    logic         r_sat;
    logic [W-1:0] w_q_inc;

    assign w_q_inc = r_q + W'(1);

    always_ff @(posedge ck) begin
        if (rst || clr) begin
            r_q   <= '0;
            r_sat <= 1'b0;
        end else if (inc && !r_sat) begin
            r_q   <= w_q_inc;
            r_sat <= (w_q_inc == MAX_Q);
        end
    end

    assign q   = r_q;
    assign sat = r_sat;

endmodule

// File: rtl/seq_det_n.sv
// Serial pattern detector with run-time pattern/length/overlap; dout 1 cycle after the completing bit.
// No backpressure: bits are consumed whenever en is high, en=0 simply stalls the history.
module seq_det_n
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               ck,
    input  logic               rst,
    input  logic               en,
    input  logic               din,
    input  logic [MAX_LEN-1:0] pat,
    input  logic [LEN_W-1:0]   len,
    input  logic               overlap,
    input  logic               clr,
    output logic               dout,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cnt_sat
);

    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    state_t             r_state;
    logic               r_dout;

    logic [MAX_LEN-1:0] w_hist_n;
    logic [MAX_LEN-1:0] w_hist_d;
    logic [MAX_LEN-1:0] w_mask;
    logic [LEN_W-1:0]   w_len;
    logic [LEN_W-1:0]   w_fill_n;
    logic [LEN_W-1:0]   w_fill_d;
    state_t             w_state_d;
    logic               w_match;
    logic               w_inc;

    assign w_len    = LEN_W'(clamp_len(32'(len), MAX_LEN));
    assign w_hist_n = {r_hist[MAX_LEN-2:0], din};
    assign w_fill_n = (r_fill >= LEN_W'(MAX_LEN)) ? r_fill : r_fill + LEN_W'(1);

    // Only the newest L history bits take part in the compare.
    assign w_mask  = {MAX_LEN{1'b1}} >> (LEN_W'(MAX_LEN) - w_len);
    assign w_match = en && (w_len != '0) && (w_fill_n >= w_len)
                     && (((w_hist_n ^ pat) & w_mask) == '0);

    always_comb begin
        w_hist_d  = r_hist;
        w_fill_d  = r_fill;
        w_state_d = r_state;
        w_inc     = 1'b0;
        if (rst || clr) begin
            w_hist_d  = '0;
            w_fill_d  = '0;
            w_state_d = IDLE;
        end else if (en) begin
            w_hist_d = w_hist_n;
            w_fill_d = (w_match && !overlap) ? '0 : w_fill_n;
            if (w_match) begin
                w_state_d = HIT;
                w_inc     = 1'b1;
            end else begin
                w_state_d = (w_fill_d >= w_len) ? ARMED : IDLE;
            end
        end else begin
            w_state_d = (r_fill >= w_len) ? ARMED : IDLE;
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_state <= IDLE;
            r_dout  <= 1'b0;
        end else begin
            r_hist  <= w_hist_d;
            r_fill  <= w_fill_d;
            r_state <= w_state_d;
            r_dout  <= (w_state_d == HIT);
        end
    end

    assign dout = r_dout;

    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .ck (ck),
        .rst(rst),
        .clr(clr),
        .inc(w_inc),
        .q  (match_cnt),
        .sat(cnt_sat)
    );

endmodule

// File: tb/tb_seq_det_n.sv
// Bench for seq_det_n: directed scenarios then randomized traffic, checked against a
// bit-queue reference model on a default instance and a 2-bit-counter instance.
module tb_seq_det_n;

    logic       ck = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       din = 1'b0;
    logic       overlap = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] pat = '0;
    logic [3:0] len = '0;

    logic       dout1, sat1, dout2, sat2;
    logic [7:0] cnt1;
    logic [1:0] cnt2;

    int n_checks = 0;
    int n_err    = 0;

    bit m_bits[$];
    int m_fill = 0;
    int m_cnt8 = 0;
    int m_cnt2 = 0;
    bit m_dout = 1'b0;

    always #5 ck = ~ck;

    seq_det_n u_dut (
        .ck(ck), .rst(rst), .en(en), .din(din), .pat(pat), .len(len),
        .overlap(overlap), .clr(clr), .dout(dout1), .match_cnt(cnt1), .cnt_sat(sat1)
    );

    seq_det_n #(.MAX_LEN(8), .CNT_W(2)) u_dut2 (
        .ck(ck), .rst(rst), .en(en), .din(din), .pat(pat), .len(len),
        .overlap(overlap), .clr(clr), .dout(dout2), .match_cnt(cnt2), .cnt_sat(sat2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: keep every consumed bit, count bits since the last restart, compare the
    // newest L bits against pat[L-1:0] (pat[0] is the newest bit).
    task automatic model_step();
        int  fill_n;
        int  l;
        bit  hit;
        if (rst || clr) begin
            m_bits.delete();
            m_fill = 0;
            m_dout = 1'b0;
            m_cnt8 = 0;
            m_cnt2 = 0;
        end else if (en) begin
            m_bits.push_back(din);
            if (m_bits.size() > 64) void'(m_bits.pop_front());
            fill_n = (m_fill + 1 > 8) ? 8 : m_fill + 1;
            l      = (int'(len) > 8) ? 8 : int'(len);
            hit    = (l > 0) && (fill_n >= l);
            for (int i = 0; i < l; i++)
                if (hit && m_bits[m_bits.size() - 1 - i] != pat[i]) hit = 1'b0;
            m_dout = hit;
            if (hit) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            m_fill = (hit && !overlap) ? 0 : fill_n;
        end else begin
            m_dout = 1'b0;
        end
    endtask

    task automatic cyc(input bit e, input bit d, input bit c, input bit r);
        en = e; din = d; clr = c; rst = r;
        @(posedge ck);
        model_step();
        #1;
        check("dout", 32'(dout1), 32'(m_dout));
        check("match_cnt", 32'(cnt1), 32'(m_cnt8));
        check("cnt_sat", 32'(sat1), 32'(m_cnt8 == 255));
        check("dout_w2", 32'(dout2), 32'(m_dout));
        check("match_cnt_w2", 32'(cnt2), 32'(m_cnt2));
        check("cnt_sat_w2", 32'(sat2), 32'(m_cnt2 == 3));
    endtask

    // Feed n bits oldest first (bits[n-1] first), with optional en=0 gaps after each bit.
    task automatic feed(input logic [31:0] bits, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            cyc(1'b1, bits[i], 1'b0, 1'b0);
            for (int g = 0; g < gap; g++) begin
                cyc(1'b0, 1'($urandom), 1'b0, 1'b0);
                check("gap_dout", 32'(dout1), 32'd0);
            end
        end
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        do_reset();
        check("reset_dout", 32'(dout1), 32'd0);
        check("reset_cnt", 32'(cnt1), 32'd0);
        check("reset_sat", 32'(sat1), 32'd0);

        pat = 8'hF3; len = 4'd2; overlap = 1'b1;
        feed(32'b0110111100, 10, 0);
        check("s1_cnt", 32'(cnt1), 32'd4);
        check("s1_last_dout", 32'(dout1), 32'd0);

        do_reset();
        overlap = 1'b0;
        feed(32'b0110111100, 10, 0);
        check("s2_cnt", 32'(cnt1), 32'd3);

        do_reset();
        pat = 8'h0D; len = 4'd4; overlap = 1'b1;
        feed(32'b1101101, 7, 0);
        check("s3_ov_cnt", 32'(cnt1), 32'd2);
        do_reset();
        overlap = 1'b0;
        feed(32'b1101101, 7, 0);
        check("s3_noov_cnt", 32'(cnt1), 32'd1);

        do_reset();
        pat = 8'h55; len = 4'd1; overlap = 1'b1;
        feed(32'b11111, 5, 0);
        check("s4_cnt_w2", 32'(cnt2), 32'd3);
        check("s4_sat_w2", 32'(sat2), 32'd1);
        check("s4_cnt", 32'(cnt1), 32'd5);

        do_reset();
        pat = 8'h0D; len = 4'd4;
        feed(32'b11, 2, 0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        feed(32'b01, 2, 0);
        check("s5_clr_cnt", 32'(cnt1), 32'd0);
        do_reset();
        feed(32'b11, 2, 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        feed(32'b01, 2, 0);
        check("s5_rst_cnt", 32'(cnt1), 32'd0);

        do_reset();
        overlap = 1'b1;
        feed(32'b1101101, 7, 2);
        check("s6_gap_cnt", 32'(cnt1), 32'd2);

        do_reset();
        len = 4'd0;
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'($urandom), 1'b0, 1'b0);
        check("s7_len0_cnt", 32'(cnt1), 32'd0);

        do_reset();
        pat = 8'hA5; len = 4'd15;
        feed(32'hA5, 8, 0);
        check("s8_clamp_dout", 32'(dout1), 32'd1);
        check("s8_clamp_cnt", 32'(cnt1), 32'd1);

        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                pat     = 8'($urandom);
                overlap = 1'($urandom);
                len     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                      : 4'($urandom_range(1, 3));
            end
            cyc(1'($urandom_range(0, 4) != 0), 1'($urandom),
                1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 199) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
